// File: rtl/instr_mem_loader.sv
// Instruction memory loader: receives a framed program image (length, N bytes,
// checksum) over a valid/ready byte stream, writes it into the instruction
// memory and holds the processor until the load has finished.
module instr_mem_loader #(
    parameter int unsigned           ADDR_WIDTH = 8,
    parameter int unsigned           DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  proc_hold,
    output logic                  load_done,
    output logic                  load_error,
    output logic [8:0]            words_loaded
);

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StData,
        StCheck,
        StDone,
        StErr
    } state_e;

    state_e                  state_q, state_d;
    logic [7:0]              len_q, len_d;
    logic [7:0]              sum_q, sum_d;
    logic [7:0]              idx_q, idx_d;
    logic [8:0]              words_q, words_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic                    accept;
    logic [7:0]              check_sum;

    assign in_ready  = (state_q == StLen) || (state_q == StData) || (state_q == StCheck);
    assign accept    = in_valid && in_ready;
    // Running sum including the checksum byte must wrap to zero for a good image.
    assign check_sum = sum_q + in_data;

    // State and datapath registers; reset cancels any pending write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            len_q       <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            words_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            sum_q       <= sum_d;
            idx_q       <= idx_d;
            words_q     <= words_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Next-state and datapath update for the framing FSM.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        sum_d       = sum_q;
        idx_d       = idx_q;
        words_d     = words_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLen;
                    words_d = '0;
                end
            end
            StLen: begin
                if (accept) begin
                    len_d   = in_data;
                    sum_d   = '0;
                    idx_d   = '0;
                    state_d = (in_data == 8'h00) ? StErr : StData;
                end
            end
            StData: begin
                if (accept) begin
                    mem_we_d    = 1'b1;
                    // Address wraps modulo the memory size.
                    mem_addr_d  = BASE_ADDR + ADDR_WIDTH'(idx_q);
                    mem_wdata_d = DATA_WIDTH'(in_data);
                    sum_d       = sum_q + in_data;
                    idx_d       = idx_q + 8'd1;
                    words_d     = words_q + 9'd1;
                    if (idx_q == len_q - 8'd1) begin
                        state_d = StCheck;
                    end
                end
            end
            StCheck: begin
                if (accept) begin
                    state_d = (check_sum == 8'h00) ? StDone : StErr;
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign words_loaded = words_q;
    // Hold is decoded from state so reset releases it asynchronously.
    assign proc_hold    = (state_q != StIdle);
    assign load_done    = (state_q == StDone);
    assign load_error   = (state_q == StErr);

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader. Two instances share stimulus: dut_a at
// base 0x00 and dut_b at base 0xFE for the address wrap-around case.
module tb_instr_mem_loader;

    logic       clock;
    logic       reset;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;

    logic       in_ready_a, mem_we_a, proc_hold_a, load_done_a, load_error_a;
    logic [7:0] mem_addr_a, mem_wdata_a;
    logic [8:0] words_a;
    logic       in_ready_b, mem_we_b, proc_hold_b, load_done_b, load_error_b;
    logic [7:0] mem_addr_b, mem_wdata_b;
    logic [8:0] words_b;

    int checks;
    int errors;
    int done_a, err_a, done_b, err_b;
    int hold_gap, ready_gap;
    bit busy, stall_watch;
    logic [15:0] wr_a[$];
    logic [15:0] wr_b[$];
    logic [15:0] exp_w[3];

    instr_mem_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .BASE_ADDR(8'h00)) dut_a (
        .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready_a), .mem_we(mem_we_a),
        .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .proc_hold(proc_hold_a),
        .load_done(load_done_a), .load_error(load_error_a), .words_loaded(words_a)
    );

    instr_mem_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .BASE_ADDR(8'hFE)) dut_b (
        .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready_b), .mem_we(mem_we_b),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .proc_hold(proc_hold_b),
        .load_done(load_done_b), .load_error(load_error_b), .words_loaded(words_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Record writes and pulses away from the active edge.
    always @(negedge clock) begin
        if (mem_we_a) wr_a.push_back({mem_addr_a, mem_wdata_a});
        if (mem_we_b) wr_b.push_back({mem_addr_b, mem_wdata_b});
        if (load_done_a) done_a++;
        if (load_error_a) err_a++;
        if (load_done_b) done_b++;
        if (load_error_b) err_b++;
        if (busy && !proc_hold_a) hold_gap++;
        if (stall_watch && !in_ready_a) ready_gap++;
    end

    task automatic clear_logs();
        wr_a.delete();
        wr_b.delete();
        done_a = 0; err_a = 0; done_b = 0; err_b = 0;
        hold_gap = 0; ready_gap = 0;
    endtask

    task automatic start_load();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    // Present one byte until accepted (bounded), then idle for 'stall' cycles.
    task automatic send_byte(input logic [7:0] b, input int stall);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clock);
            ok = in_ready_a;
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        in_data  = 8'hA5;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout byte=%h got no in_ready want in_ready=1", b);
        end
        repeat (stall) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic stream(input logic [7:0] chk, input int stall);
        send_byte(8'h03, stall);
        send_byte(8'h21, stall);
        send_byte(8'h42, stall);
        send_byte(8'h63, stall);
        send_byte(chk, 0);
    endtask

    task automatic test_reset();
        #3;
        checks++; if (in_ready_a !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready_a); end
        checks++; if (mem_we_a !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %b want 0", mem_we_a); end
        checks++; if (proc_hold_a !== 1'b0) begin errors++; $display("FAIL rst_proc_hold got %b want 0", proc_hold_a); end
        checks++; if ({load_done_a, load_error_a} !== 2'b00) begin errors++; $display("FAIL rst_pulses got %b want 00", {load_done_a, load_error_a}); end
        checks++; if (mem_addr_a !== 8'h00) begin errors++; $display("FAIL rst_mem_addr_a got %h want 00", mem_addr_a); end
        checks++; if (mem_addr_b !== 8'hFE) begin errors++; $display("FAIL rst_mem_addr_b got %h want fe", mem_addr_b); end
        checks++; if (mem_wdata_a !== 8'h00) begin errors++; $display("FAIL rst_mem_wdata got %h want 00", mem_wdata_a); end
        checks++; if (words_a !== 9'd0) begin errors++; $display("FAIL rst_words got %0d want 0", words_a); end
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_good_load(input string tag, input int stall);
        clear_logs();
        start_load();
        busy = 1'b1;
        stall_watch = (stall != 0);
        checks++; if (proc_hold_a !== 1'b1) begin errors++; $display("FAIL %s_hold_start got %b want 1", tag, proc_hold_a); end
        stream(8'h3A, stall);
        stall_watch = 1'b0;
        checks++; if (load_done_a !== 1'b1) begin errors++; $display("FAIL %s_done_now got %b want 1", tag, load_done_a); end
        checks++; if (proc_hold_a !== 1'b1) begin errors++; $display("FAIL %s_hold_done got %b want 1", tag, proc_hold_a); end
        busy = 1'b0;
        @(posedge clock); #1;
        checks++; if (proc_hold_a !== 1'b0) begin errors++; $display("FAIL %s_hold_after got %b want 0", tag, proc_hold_a); end
        checks++; if (load_done_a !== 1'b0) begin errors++; $display("FAIL %s_done_after got %b want 0", tag, load_done_a); end
        exp_w[0] = 16'h0021; exp_w[1] = 16'h0142; exp_w[2] = 16'h0263;
        checks++; if (wr_a.size() != 3) begin errors++; $display("FAIL %s_write_count got %0d want 3", tag, wr_a.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= wr_a.size() || wr_a[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL %s_write%0d got %h want %h", tag, i, (i < wr_a.size()) ? wr_a[i] : 16'hxxxx, exp_w[i]);
            end
        end
        checks++; if (done_a != 1 || err_a != 0) begin errors++; $display("FAIL %s_pulses got done=%0d err=%0d want 1 0", tag, done_a, err_a); end
        checks++; if (words_a !== 9'd3) begin errors++; $display("FAIL %s_words got %0d want 3", tag, words_a); end
        checks++; if (hold_gap != 0) begin errors++; $display("FAIL %s_hold_gap got %0d want 0", tag, hold_gap); end
        if (stall != 0) begin
            checks++; if (ready_gap != 0) begin errors++; $display("FAIL %s_ready_gap got %0d want 0", tag, ready_gap); end
        end
    endtask

    task automatic test_bad_checksum();
        clear_logs();
        start_load();
        stream(8'h3B, 0);
        checks++; if (load_error_a !== 1'b1) begin errors++; $display("FAIL bad_err_now got %b want 1", load_error_a); end
        @(posedge clock); #1;
        checks++; if (wr_a.size() != 3) begin errors++; $display("FAIL bad_write_count got %0d want 3", wr_a.size()); end
        checks++; if (done_a != 0 || err_a != 1) begin errors++; $display("FAIL bad_pulses got done=%0d err=%0d want 0 1", done_a, err_a); end
        checks++; if (proc_hold_a !== 1'b0) begin errors++; $display("FAIL bad_hold_after got %b want 0", proc_hold_a); end
    endtask

    // Start and in_valid together: the length byte must be taken in LEN, not IDLE.
    task automatic test_zero_length();
        clear_logs();
        in_valid = 1'b1;
        in_data  = 8'h00;
        start    = 1'b1;
        #1;
        checks++; if (in_ready_a !== 1'b0) begin errors++; $display("FAIL zero_idle_ready got %b want 0", in_ready_a); end
        @(posedge clock); #1;
        start = 1'b0;
        checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL zero_len_ready got %b want 1", in_ready_a); end
        send_byte(8'h00, 0);
        checks++; if (load_error_a !== 1'b1) begin errors++; $display("FAIL zero_err_now got %b want 1", load_error_a); end
        @(posedge clock); #1;
        checks++; if (load_error_a !== 1'b0) begin errors++; $display("FAIL zero_err_after got %b want 0", load_error_a); end
        checks++; if (wr_a.size() != 0) begin errors++; $display("FAIL zero_writes got %0d want 0", wr_a.size()); end
        checks++; if (err_a != 1 || done_a != 0) begin errors++; $display("FAIL zero_pulses got err=%0d done=%0d want 1 0", err_a, done_a); end
        checks++; if (words_a !== 9'd0) begin errors++; $display("FAIL zero_words got %0d want 0", words_a); end
    endtask

    task automatic test_reset_mid_load();
        start_load();
        send_byte(8'h03, 0);
        send_byte(8'h21, 0);
        send_byte(8'h42, 0);
        checks++; if (mem_we_a !== 1'b1) begin errors++; $display("FAIL mid_we_pending got %b want 1", mem_we_a); end
        #1 reset = 1'b1;
        #1;
        checks++; if (proc_hold_a !== 1'b0) begin errors++; $display("FAIL mid_hold got %b want 0", proc_hold_a); end
        checks++; if (mem_we_a !== 1'b0) begin errors++; $display("FAIL mid_we got %b want 0", mem_we_a); end
        checks++; if (in_ready_a !== 1'b0) begin errors++; $display("FAIL mid_ready got %b want 0", in_ready_a); end
        checks++; if (words_a !== 9'd0) begin errors++; $display("FAIL mid_words got %0d want 0", words_a); end
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        test_good_load("after_rst", 0);
    endtask

    task automatic test_wrap_start_ignore();
        clear_logs();
        start_load();
        send_byte(8'h03, 0);
        send_byte(8'h21, 0);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        checks++; if (in_ready_b !== 1'b1) begin errors++; $display("FAIL wrap_still_data got %b want 1", in_ready_b); end
        send_byte(8'h42, 0);
        send_byte(8'h63, 0);
        send_byte(8'h3A, 0);
        @(posedge clock); #1;
        exp_w[0] = 16'hFE21; exp_w[1] = 16'hFF42; exp_w[2] = 16'h0063;
        checks++; if (wr_b.size() != 3) begin errors++; $display("FAIL wrap_write_count got %0d want 3", wr_b.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= wr_b.size() || wr_b[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL wrap_write%0d got %h want %h", i, (i < wr_b.size()) ? wr_b[i] : 16'hxxxx, exp_w[i]);
            end
        end
        checks++; if (done_b != 1 || err_b != 0) begin errors++; $display("FAIL wrap_pulses got done=%0d err=%0d want 1 0", done_b, err_b); end
        checks++; if (words_b !== 9'd3) begin errors++; $display("FAIL wrap_words got %0d want 3", words_b); end
        checks++; if (proc_hold_b !== 1'b0) begin errors++; $display("FAIL wrap_hold_after got %b want 0", proc_hold_b); end
    endtask

    initial begin
        checks = 0; errors = 0;
        busy = 1'b0; stall_watch = 1'b0;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        clear_logs();
        test_reset();
        test_good_load("good", 0);
        test_bad_checksum();
        test_zero_length();
        test_good_load("stall", 3);
        test_reset_mid_load();
        test_wrap_start_ignore();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
